// File: rtl/serial_signed_pow2_divider_pkg.sv
// serial_signed_pow2_divider_pkg: shared types and helpers for the serial
// signed power-of-two divider (FSM state encoding, default width, and the
// rounding-correction rule also used by the bench's reference model).
// Latency: n/a (package). Backpressure: n/a (package).
package serial_signed_pow2_divider_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // An arithmetic shift floors. Truncation toward zero differs from the
  // floor only for a negative operand that lost a 1 bit (inexact), where
  // the result must move up by one.
  function automatic logic round_corr(input logic div, input logic sign,
                                      input logic sticky);
    return div & sign & sticky;
  endfunction

endpackage

// File: rtl/serial_signed_pow2_divider_sra1_step.sv
// sra1_step: one-bit arithmetic right shift of acc, also exposing the bit
// that falls off the bottom. Combinational, 0 cycles, no flow control.
// Ports: acc_i (N) operand in; res_o (N+1) = {acc_shifted, shifted_out_bit}.
module sra1_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] acc_i,
  output logic [N:0]   res_o
);

  // {acc[N-1], acc[N-1:1], acc[0]} collapses to {acc[N-1], acc}.
  assign res_o = {acc_i[N-1], acc_i};

endmodule

// File: rtl/serial_signed_pow2_divider.sv
// serial_signed_pow2_divider: signed a / 2**s, either floor (arithmetic
// shift) or truncate-toward-zero, computed one bit per cycle.
// Latency: out_valid high s+1 cycles after the accept cycle (1 for s=0);
// backpressure: result held in DONE until out_ready, in_ready low while busy.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_shamt/
// in_div command side; out_valid/out_ready/out_data result side.
module serial_signed_pow2_divider
  import serial_signed_pow2_divider_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  input  logic          in_div,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          div_q, div_d;
  logic          sign_q, sign_d;
  logic          sticky_q, sticky_d;
  logic [N-1:0]  out_q, out_d;

  logic [N:0]    step_res;
  logic [N-1:0]  acc_sh;
  logic          shout;

  sra1_step #(.N(N)) u_step (
    .acc_i (acc_q),
    .res_o (step_res)
  );

  assign acc_sh = step_res[N:1];
  assign shout  = step_res[0];

  // Handshake outputs come straight from registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    out_d    = out_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d    = in_data;
          cnt_d    = in_shamt;
          div_d    = in_div;
          sign_d   = in_data[N-1];
          sticky_d = 1'b0;
          if (in_shamt != '0) begin
            state_d = SHIFT;
          end else begin
            // Zero shift is exact in both modes: pass the operand through.
            state_d = DONE;
            out_d   = in_data;
          end
        end
      end

      SHIFT: begin
        sticky_d = sticky_q | shout;
        acc_d    = acc_sh;
        cnt_d    = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = DONE;
          // Cannot overflow: correction only applies to a negative operand
          // shifted by at least one, so acc_sh is at most -1.
          out_d   = acc_sh + N'(round_corr(div_q, sign_q, sticky_d));
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_signed_pow2_divider.sv
// tb_serial_signed_pow2_divider: directed and exhaustive checks of the
// serial signed power-of-two divider at N=8.
// Inputs driven 1 time unit after each rising edge, outputs sampled there.
module tb_serial_signed_pow2_divider;
  import serial_signed_pow2_divider_pkg::*;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic          in_div;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  int tests;
  int fails;

  serial_signed_pow2_divider #(.N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_div    (in_div),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: floor via >>>, inexactness via a bit mask.
  function automatic logic [N-1:0] ref_model(input logic [N-1:0] a,
                                             input int s, input logic dv);
    logic signed [N-1:0] sa;
    logic [N-1:0] r;
    logic [N-1:0] m;
    sa = a;
    r  = sa >>> s;
    m  = (8'd1 << s) - 8'd1;
    return r + N'(round_corr(dv, a[N-1], |(a & m)));
  endfunction

  // Issue one command from IDLE, wait for the result, then consume it.
  // lat counts the accept cycle as 0; a timeout returns lat >= 40.
  task automatic run_cmd(input logic [N-1:0] d, input int s, input logic dv,
                         output logic [N-1:0] res, output int lat);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s[SW-1:0];
    in_div   = dv;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    res = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    in_shamt = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
        fails++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_data=%h, want 1 0 00",
                 i, in_ready, out_valid, out_data);
      end
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_positive();
    logic [N-1:0] res;
    int lat;
    for (int dv = 0; dv < 2; dv++) begin
      run_cmd(8'd100, 3, dv[0], res, lat);
      tests++;
      if (res !== 8'd12 || lat !== 4) begin
        fails++;
        $display("FAIL positive div=%0d: got %h lat %0d, want 0c lat 4", dv, res, lat);
      end
    end
  endtask

  task automatic test_negative();
    logic [N-1:0] res;
    int lat;
    run_cmd(8'hF9, 2, 1'b0, res, lat);
    tests++;
    if (res !== 8'hFE || lat !== 3) begin
      fails++;
      $display("FAIL neg_floor: got %h lat %0d, want fe lat 3", res, lat);
    end
    run_cmd(8'hF9, 2, 1'b1, res, lat);
    tests++;
    if (res !== 8'hFF || lat !== 3) begin
      fails++;
      $display("FAIL neg_trunc: got %h lat %0d, want ff lat 3", res, lat);
    end
    run_cmd(8'hFF, 5, 1'b1, res, lat);
    tests++;
    if (res !== 8'h00 || lat !== 6) begin
      fails++;
      $display("FAIL m1_trunc: got %h lat %0d, want 00 lat 6", res, lat);
    end
    run_cmd(8'hFF, 5, 1'b0, res, lat);
    tests++;
    if (res !== 8'hFF || lat !== 6) begin
      fails++;
      $display("FAIL m1_floor: got %h lat %0d, want ff lat 6", res, lat);
    end
  endtask

  task automatic test_edges();
    logic [N-1:0] res;
    int lat;
    run_cmd(8'h80, 3, 1'b1, res, lat);
    tests++;
    if (res !== 8'hF0 || lat !== 4) begin
      fails++;
      $display("FAIL minval_exact: got %h lat %0d, want f0 lat 4", res, lat);
    end
    run_cmd(8'hFB, 0, 1'b1, res, lat);
    tests++;
    if (res !== 8'hFB || lat !== 1) begin
      fails++;
      $display("FAIL shamt0: got %h lat %0d, want fb lat 1", res, lat);
    end
    run_cmd(8'h7F, 7, 1'b0, res, lat);
    tests++;
    if (res !== 8'h00 || lat !== 8) begin
      fails++;
      $display("FAIL shamt7: got %h lat %0d, want 00 lat 8", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] held;
    int lat;
    // Command A: 0x40 >> 2 = 0x10; command B presented while A is busy.
    in_valid = 1'b1;
    in_data  = 8'h40;
    in_shamt = 3'd2;
    in_div   = 1'b0;
    tick();
    in_data  = 8'hF9;
    in_shamt = 3'd2;
    in_div   = 1'b1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    held = out_data;
    tests++;
    if (held !== 8'h10 || lat !== 3) begin
      fails++;
      $display("FAIL b2b_first: got %h lat %0d, want 10 lat 3", held, lat);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall[%0d]: out_valid=%b out_data=%h in_ready=%b, want 1 10 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: in_ready=%b, want 0", in_ready);
    end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    tests++;
    if (out_data !== 8'hFF || lat !== 3) begin
      fails++;
      $display("FAIL b2b_second: got %h lat %0d, want ff lat 3", out_data, lat);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] res;
    int lat;
    int seen;
    in_valid = 1'b1;
    in_data  = 8'h80;
    in_shamt = 3'd7;
    in_div   = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL midrst_noresult: out_valid seen %0d cycles, want 0", seen);
    end
    run_cmd(8'd100, 3, 1'b0, res, lat);
    tests++;
    if (res !== 8'd12 || lat !== 4) begin
      fails++;
      $display("FAIL midrst_after: got %h lat %0d, want 0c lat 4", res, lat);
    end
  endtask

  task automatic test_sweep();
    logic [N-1:0] res;
    logic [N-1:0] exp;
    int lat;
    for (int dv = 0; dv < 2; dv++) begin
      for (int s = 0; s < 8; s++) begin
        for (int v = 0; v < 256; v++) begin
          run_cmd(v[7:0], s, dv[0], res, lat);
          exp = ref_model(v[7:0], s, dv[0]);
          tests++;
          if (res !== exp || lat !== s + 1) begin
            fails++;
            $display("FAIL sweep a=%h s=%0d div=%0d: got %h lat %0d, want %h lat %0d",
                     v[7:0], s, dv, res, lat, exp, s + 1);
          end
        end
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_div    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_positive();
    test_negative();
    test_edges();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
